// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// registers the fetched word and its PC for the decoder. Handles redirects, HALT and a cycle counter.
module fetch_unit #(
  parameter int instr_width = 9,
  parameter int pc_width    = 10,
  parameter int off_width   = 8,
  parameter int cnt_width   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [pc_width-1:0]    start_addr,
  output logic [pc_width-1:0]    imem_addr,
  input  logic [instr_width-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   halt,
  input  logic                   branch_taken,
  input  logic [off_width-1:0]   branch_offset,
  input  logic                   jump,
  input  logic [pc_width-1:0]    jump_target,
  output logic [instr_width-1:0] instruction,
  output logic [pc_width-1:0]    instr_pc,
  output logic                   instr_valid,
  output logic                   done,
  output logic [cnt_width-1:0]   cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [pc_width-1:0]    pc_reg;
  logic [instr_width-1:0] instr_reg;
  logic [pc_width-1:0]    instr_pc_reg;
  logic                   instr_valid_reg;
  logic                   done_reg;
  logic [cnt_width-1:0]   cycle_count_reg;

  logic [pc_width-1:0]    branch_target;
  logic [pc_width-1:0]    pc_inc;
  logic                   cnt_saturated;

  // Target is relative to the PC of the branch itself; the sum wraps naturally.
  assign branch_target = instr_pc_reg + pc_width'($signed(branch_offset));
  assign pc_inc        = pc_reg + pc_width'(1);
  assign cnt_saturated = &cycle_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
      done_reg        <= 1'b0;
      cycle_count_reg <= '0;
    end else if (start) begin
      state_reg       <= RUN;
      pc_reg          <= start_addr;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
      done_reg        <= 1'b0;
      cycle_count_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (!cnt_saturated) begin
            cycle_count_reg <= cycle_count_reg + cnt_width'(1);
          end
          // Halt and redirects act on the word in the fetch/decode register and win over stall.
          if (halt && instr_valid_reg) begin
            state_reg       <= HALTED;
            done_reg        <= 1'b1;
            instr_valid_reg <= 1'b0;
          end else if (jump && instr_valid_reg) begin
            pc_reg          <= jump_target;
            instr_valid_reg <= 1'b0;
          end else if (branch_taken && instr_valid_reg) begin
            pc_reg          <= branch_target;
            instr_valid_reg <= 1'b0;
          end else if (!stall) begin
            instr_reg       <= imem_rdata;
            instr_pc_reg    <= pc_reg;
            instr_valid_reg <= 1'b1;
            pc_reg          <= pc_inc;
          end
        end
        default: begin
          state_reg <= state_reg;
        end
      endcase
    end
  end

  assign imem_addr   = pc_reg;
  assign instruction = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign done        = done_reg;
  assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch/jump redirects, stall, halt,
// counter saturation and asynchronous reset, against a behavioural ROM.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  start_addr;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_rdata;
  logic        stall;
  logic        halt;
  logic        branch_taken;
  logic [7:0]  branch_offset;
  logic        jump;
  logic [9:0]  jump_target;
  logic [8:0]  instruction;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        done;
  logic [15:0] cycle_count;

  int errors = 0;
  int checks = 0;

  logic [8:0] rom [0:1023];

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr];

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .halt         (halt),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .instruction  (instruction),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .done         (done),
    .cycle_count  (cycle_count)
  );

  function automatic logic [8:0] rom_word(input int a);
    return 9'((a * 37 + 5) & 32'h1FF);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] addr);
    start_addr = addr;
    start      = 1'b1;
    step(1);
    start      = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (imem_addr !== 10'h000) begin errors++; $display("FAIL reset_pc: got %h expected 000", imem_addr); end
    checks++; if (instruction !== 9'h000 || instr_pc !== 10'h000) begin errors++; $display("FAIL reset_instr: got %h/%h expected 000/000", instruction, instr_pc); end
    checks++; if (done !== 1'b0 || cycle_count !== 16'h0000) begin errors++; $display("FAIL reset_done_cnt: got %b/%h expected 0/0000", done, cycle_count); end
    rst_n = 1'b1;
    step(2);
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'h000 || cycle_count !== 16'h0000) begin errors++; $display("FAIL idle_hold: got %b/%h/%h expected 0/000/0000", instr_valid, imem_addr, cycle_count); end
    $display("test_reset done at %0t", $time);
  endtask

  task automatic test_sequential;
    do_start(10'h010);
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'h010 || cycle_count !== 16'h0000) begin errors++; $display("FAIL start_state: got %b/%h/%h expected 0/010/0000", instr_valid, imem_addr, cycle_count); end
    for (int k = 0; k < 3; k++) begin
      step(1);
      checks++; if (instr_pc !== 10'(10'h010 + k) || instruction !== rom_word(16 + k) || instr_valid !== 1'b1) begin
        errors++; $display("FAIL seq_%0d: got pc=%h ins=%h v=%b expected pc=%h ins=%h v=1", k, instr_pc, instruction, instr_valid, 10'(10'h010 + k), rom_word(16 + k));
      end
    end
    checks++; if (cycle_count !== 16'd3) begin errors++; $display("FAIL seq_count: got %0d expected 3", cycle_count); end
    $display("test_sequential done at %0t", $time);
  endtask

  task automatic test_branch;
    do_start(10'h020);
    halt = 1'b1;  // ignored: nothing valid in the register yet
    step(1);
    halt = 1'b0;
    checks++; if (instr_pc !== 10'h020 || instr_valid !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL halt_ignored: got pc=%h v=%b d=%b expected 020/1/0", instr_pc, instr_valid, done); end
    branch_taken  = 1'b1;
    branch_offset = 8'hFC;
    step(1);
    branch_taken  = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'h01C) begin errors++; $display("FAIL beq_bubble: got v=%b addr=%h expected 0/01C", instr_valid, imem_addr); end
    step(1);
    checks++; if (instr_pc !== 10'h01C || instr_valid !== 1'b1 || instruction !== rom_word(28)) begin errors++; $display("FAIL beq_target: got pc=%h v=%b ins=%h expected 01C/1/%h", instr_pc, instr_valid, instruction, rom_word(28)); end
    do_start(10'h020);
    step(1);
    step(1);
    checks++; if (instr_pc !== 10'h021 || instr_valid !== 1'b1) begin errors++; $display("FAIL beq_not_taken: got pc=%h v=%b expected 021/1", instr_pc, instr_valid); end
    $display("test_branch done at %0t", $time);
  endtask

  task automatic test_jump_wrap;
    do_start(10'h005);
    step(1);
    jump        = 1'b1;
    jump_target = 10'h3FF;
    step(1);
    jump        = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'h3FF) begin errors++; $display("FAIL jr_bubble: got v=%b addr=%h expected 0/3FF", instr_valid, imem_addr); end
    step(1);
    checks++; if (instr_pc !== 10'h3FF || instruction !== rom_word(1023) || instr_valid !== 1'b1) begin errors++; $display("FAIL jr_target: got pc=%h ins=%h v=%b expected 3FF/%h/1", instr_pc, instruction, instr_valid, rom_word(1023)); end
    step(1);
    checks++; if (instr_pc !== 10'h000 || instruction !== rom_word(0) || imem_addr !== 10'h001) begin errors++; $display("FAIL pc_wrap: got pc=%h ins=%h addr=%h expected 000/%h/001", instr_pc, instruction, imem_addr, rom_word(0)); end
    $display("test_jump_wrap done at %0t", $time);
  endtask

  task automatic test_stall_halt;
    do_start(10'h040);
    step(1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      checks++; if (instr_pc !== 10'h040 || instr_valid !== 1'b1 || imem_addr !== 10'h041) begin errors++; $display("FAIL stall_%0d: got pc=%h v=%b addr=%h expected 040/1/041", k, instr_pc, instr_valid, imem_addr); end
    end
    jump        = 1'b1;
    jump_target = 10'h050;
    step(1);
    jump  = 1'b0;
    stall = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'h050) begin errors++; $display("FAIL jr_over_stall: got v=%b addr=%h expected 0/050", instr_valid, imem_addr); end
    step(1);
    checks++; if (instr_pc !== 10'h050 || instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_050: got pc=%h v=%b expected 050/1", instr_pc, instr_valid); end
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    checks++; if (done !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 10'h051) begin errors++; $display("FAIL halt: got d=%b v=%b addr=%h expected 1/0/051", done, instr_valid, imem_addr); end
    checks++; if (cycle_count !== 16'd7) begin errors++; $display("FAIL halt_count: got %0d expected 7", cycle_count); end
    step(3);
    checks++; if (cycle_count !== 16'd7 || imem_addr !== 10'h051 || done !== 1'b1) begin errors++; $display("FAIL halted_hold: got cnt=%0d addr=%h d=%b expected 7/051/1", cycle_count, imem_addr, done); end
    do_start(10'h060);
    checks++; if (done !== 1'b0 || cycle_count !== 16'd0 || imem_addr !== 10'h060) begin errors++; $display("FAIL restart: got d=%b cnt=%0d addr=%h expected 0/0/060", done, cycle_count, imem_addr); end
    step(1);
    checks++; if (cycle_count !== 16'd1 || instr_pc !== 10'h060 || instr_valid !== 1'b1) begin errors++; $display("FAIL restart_run: got cnt=%0d pc=%h v=%b expected 1/060/1", cycle_count, instr_pc, instr_valid); end
    $display("test_stall_halt done at %0t", $time);
  endtask

  task automatic test_saturation;
    do_start(10'h000);
    step(65534);
    checks++; if (cycle_count !== 16'hFFFE) begin errors++; $display("FAIL cnt_fffe: got %h expected FFFE", cycle_count); end
    step(1);
    checks++; if (cycle_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_ffff: got %h expected FFFF", cycle_count); end
    step(4465);
    checks++; if (cycle_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate: got %h expected FFFF", cycle_count); end
    $display("test_saturation done at %0t", $time);
  endtask

  task automatic test_async_reset;
    do_start(10'h100);
    step(3);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'h000 || instr_pc !== 10'h000) begin errors++; $display("FAIL async_rst_pc: got v=%b addr=%h pc=%h expected 0/000/000", instr_valid, imem_addr, instr_pc); end
    checks++; if (instruction !== 9'h000 || done !== 1'b0 || cycle_count !== 16'h0000) begin errors++; $display("FAIL async_rst_misc: got ins=%h d=%b cnt=%h expected 000/0/0000", instruction, done, cycle_count); end
    #3;
    rst_n = 1'b1;
    step(2);
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 10'h000 || cycle_count !== 16'h0000) begin errors++; $display("FAIL post_rst_idle: got v=%b addr=%h cnt=%h expected 0/000/0000", instr_valid, imem_addr, cycle_count); end
    $display("test_async_reset done at %0t", $time);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) rom[a] = rom_word(a);
    start         = 1'b0;
    start_addr    = '0;
    stall         = 1'b0;
    halt          = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = '0;
    jump          = 1'b0;
    jump_target   = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump_wrap();
    test_stall_halt();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
